mod_reduce_barrett: RTL and testbench

MOD_REDUCE_BARRETT -- requirements
Module: mod_reduce_barrett

---
 rtl/mod_reduce_barrett.sv | 185 ++++++++++++++++++
 tb/tb_mod_reduce_barrett.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_barrett.sv
// Purpose: Barrett reduction x mod Q for 2*Q_WIDTH-bit products, feeding a circular output FIFO.
// Latency: 3 cycles from i_valid to FIFO write, 1 input per cycle; o_valid is count != 0.
// Backpressure: none on the input; upstream paces itself with the registered o_credit_ok, and overflow is sticky.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (clears all in-flight and buffered data)
//   i_valid, i_x          product from the multiplier, captured every valid cycle
//   o_credit_ok           upstream may issue one new multiply this cycle
//   o_valid, i_ready, o_r FIFO head residue with valid/ready handshake
//   o_overflow            sticky: a result was dropped because the FIFO was full
//   o_range_err           sticky: an input was >= Q*Q (only built with MOD_REDUCE_RANGE_CHECK_EN)
// Optional feature macro: MOD_REDUCE_RANGE_CHECK_EN
module mod_reduce_barrett #(
    parameter int Q_WIDTH    = 16,
    parameter int Q          = 65521,
    parameter int FIFO_DEPTH = 8,
    parameter int LOOKAHEAD  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [2*Q_WIDTH-1:0]   i_x,
    output logic                   o_credit_ok,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [Q_WIDTH-1:0]     o_r,
    output logic                   o_overflow,
    output logic                   o_range_err
);

    localparam int XW = 2 * Q_WIDTH;
    localparam int RW = Q_WIDTH + 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // MU = floor(2^(2*Q_WIDTH) / Q) needs one bit more than XW for the numerator.
    localparam logic [XW:0]      POW2 = {1'b1, {XW{1'b0}}};
    localparam logic [Q_WIDTH:0] MU   = (Q_WIDTH + 1)'(POW2 / (XW + 1)'(Q));
    localparam logic [RW-1:0]    Q_R  = RW'(Q);

    // ---------------- S1: capture x and q2 ----------------
    logic [Q_WIDTH:0] x_hi;
    logic [XW+1:0]    q2_next;
    logic             s1_vld;
    logic [XW-1:0]    s1_x;
    logic [XW+1:0]    s1_q2;

    assign x_hi    = i_x[XW-1:Q_WIDTH-1];
    assign q2_next = (XW + 2)'(x_hi) * (XW + 2)'(MU);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_q2  <= '0;
        end else begin
            s1_vld <= i_valid;
            if (i_valid) begin
                s1_x  <= i_x;
                s1_q2 <= q2_next;
            end
        end
    end

    // ---------------- S2: r = x - q3*Q, modulo 2^(Q_WIDTH+2) ----------------
    // The true remainder is below 3Q, so only the low Q_WIDTH+2 bits matter.
    logic [Q_WIDTH:0] q3;
    logic [RW-1:0]    r_next;
    logic             s2_vld;
    logic [RW-1:0]    s2_r;

    assign q3     = (Q_WIDTH + 1)'(s1_q2 >> (Q_WIDTH + 1));
    assign r_next = RW'(s1_x) - (RW'(q3) * Q_R);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld <= 1'b0;
            s2_r   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_r <= r_next;
            end
        end
    end

    // ---------------- S3: up to two conditional subtractions ----------------
    logic [RW-1:0]      fold1;
    logic [RW-1:0]      fold2;
    logic               s3_vld;
    logic [Q_WIDTH-1:0] s3_r;

    assign fold1 = (s2_r  >= Q_R) ? (s2_r  - Q_R) : s2_r;
    assign fold2 = (fold1 >= Q_R) ? (fold1 - Q_R) : fold1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3_vld <= 1'b0;
            s3_r   <= '0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_r <= Q_WIDTH'(fold2);
            end
        end
    end

    // ---------------- Output FIFO ----------------
    logic [Q_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               pop;
    logic               wr_en;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign o_valid = (count != '0);
    assign o_r     = o_valid ? mem[rd_ptr] : '0;
    assign pop     = o_valid && i_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign wr_en   = s3_vld && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s3_r;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_en && pop) begin
                count <= count - CW'(1);
            end
            if (s3_vld && !wr_en) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // ---------------- Credit ----------------
    // Everything already committed (buffered or in the pipe) plus what upstream may
    // still have in flight must fit in the FIFO.
    logic [CW:0] occ;

    assign occ = (CW + 1)'(count) + (CW + 1)'(s1_vld) + (CW + 1)'(s2_vld) + (CW + 1)'(s3_vld);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_credit_ok <= 1'b0;
        end else begin
            o_credit_ok <= ((int'(occ) + LOOKAHEAD) < FIFO_DEPTH);
        end
    end

    // ---------------- Optional input range check ----------------
`ifdef MOD_REDUCE_RANGE_CHECK_EN
    localparam logic [XW-1:0] Q_X  = XW'(Q);
    localparam logic [XW-1:0] Q_SQ = Q_X * Q_X;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_range_err <= 1'b0;
        end else if (i_valid && (i_x >= Q_SQ)) begin
            o_range_err <= 1'b1;
        end
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_reduce_barrett.sv
module tb_mod_reduce_barrett;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_x;
    logic        o_credit_ok;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_r;
    logic        o_overflow;
    logic        o_range_err;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    mod_reduce_barrett dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_x         (i_x),
        .o_credit_ok (o_credit_ok),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_r         (o_r),
        .o_overflow  (o_overflow),
        .o_range_err (o_range_err)
    );

    // Directed vectors, residues computed by hand for Q = 65521.
    logic [31:0] vx [9] = '{32'd0, 32'd65521, 32'd65522, 32'd131042, 32'd65520,
                            32'd1000000, 32'd123456789, 32'd4292870400, 32'd4293001440};
    logic [15:0] vr [9] = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd65520,
                            16'd17185, 16'd15225, 16'd1, 16'd65520};

`ifdef MOD_REDUCE_RANGE_CHECK_EN
    localparam logic RANGE_EXP = 1'b1;
`else
    localparam logic RANGE_EXP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // x = k*Q + 7k reduces to 7k for small k.
    function automatic logic [31:0] seq_x(input int k);
        return 32'(k * 65521 + 7 * k);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int fed;
        int stale;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_x     = '0;
        i_ready = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_valid",    o_valid,     0);
        chk("rst_credit",   o_credit_ok, 0);
        chk("rst_overflow", o_overflow,  0);
        chk("rst_range",    o_range_err, 0);
        chk("rst_r",        o_r,         0);

        i_rst_n = 1'b1;
        #1;
        chk("credit_before_edge", o_credit_ok, 0);
        step();
        chk("credit_first_edge", o_credit_ok, 1);

        // Single product: (Q-1)^2 -> 1, valid four cycles after issue
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_x     = 32'd4292870400;
        step();
        i_valid = 1'b0;
        i_x     = '0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", lat, 4);
        chk("single_r", o_r, 1);
        step();
        chk("single_drained", o_valid, 0);

        // Back-to-back stream, results on consecutive cycles in order
        for (int t = 0; t < 12; t++) begin
            if (t < 9) begin
                i_valid = 1'b1;
                i_x     = vx[t];
            end else begin
                i_valid = 1'b0;
                i_x     = '0;
            end
            step();
            if (t >= 3) begin
                chk($sformatf("stream_vld%0d", t - 3), o_valid, 1);
                chk($sformatf("stream_r%0d", t - 3), o_r, vr[t - 3]);
            end
        end
        step();
        chk("stream_done", o_valid, 0);
        chk("range_clean", o_range_err, 0);
        repeat (4) step();

        // Credit-paced feed with a stalled consumer
        i_ready = 1'b0;
        fed = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_credit_ok) begin
                i_valid = 1'b1;
                i_x     = seq_x(fed);
                fed++;
            end else begin
                i_valid = 1'b0;
            end
            step();
        end
        i_valid = 1'b0;
        chk("credit_fed", fed, 5);
        chk("credit_low", o_credit_ok, 0);
        chk("credit_no_ovf", o_overflow, 0);
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("credit_drain_vld%0d", k), o_valid, 1);
            chk($sformatf("credit_drain_r%0d", k), o_r, 7 * k);
            step();
        end
        chk("credit_drain_empty", o_valid, 0);
        step();
        chk("credit_back", o_credit_ok, 1);

        // Overflow: 12 unpaced inputs into an 8-deep FIFO
        i_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            i_valid = 1'b1;
            i_x     = seq_x(k);
            step();
            if (k == 10) chk("ovf_after_8th", o_overflow, 0);
            if (k == 11) chk("ovf_after_9th", o_overflow, 1);
        end
        i_valid = 1'b0;
        repeat (4) step();
        chk("ovf_sticky", o_overflow, 1);
        chk("ovf_credit", o_credit_ok, 0);
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_drain_r%0d", k), o_r, 7 * k);
            step();
        end
        chk("ovf_drain_empty", o_valid, 0);

        // Reset with 3 in flight and 2 buffered
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_x     = seq_x(k + 1);
            step();
        end
        i_valid = 1'b0;
        chk("pre_rst_valid", o_valid, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid",    o_valid,     0);
        chk("midrst_credit",   o_credit_ok, 0);
        chk("midrst_overflow", o_overflow,  0);
        chk("midrst_r",        o_r,         0);
        step();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_valid) stale++;
        end
        chk("no_stale", stale, 0);
        chk("post_rst_credit", o_credit_ok, 1);

        // Range check on Q*Q
        i_valid = 1'b1;
        i_x     = 32'd4293001441;
        step();
        i_valid = 1'b0;
        repeat (5) step();
        chk("range_err", o_range_err, RANGE_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
